pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised elastic pipeline register that replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable stage. It carries an opaque payload of configurable width with valid/ready handshakes on both sides. A two-entry skid buffer gives full throughput with a registered upstream ready. A synchronous flush turns the stage into a bubble, and an idle stage presents a parameterised bubble word instead of zeros.

## Interface
- DATA_W, 64, payload width in bits; legal range 1..1024.
- BUBBLE_DATA, '0, DATA_W-bit value driven on OutData when the stage holds no valid entry. Stages use it to encode NOP control, e.g. a dummy write-register field.
- Clk  in  1  rising-edge clock; the block has one clock.
- Rst  in  1  synchronous reset, active-high.
- Flush  in  1  synchronous flush; discards all held entries.
- InValid  in  1  upstream entry valid.
- InReady  out  1  stage can accept; registered, no combinational path from OutReady.
- InData  in  DATA_W  upstream payload.
- OutValid  out  1  OutData holds a valid entry.
- OutReady  in  1  downstream accepts.
- OutData  out  DATA_W  head payload, or BUBBLE_DATA when OutValid=0.
- Occupancy  out  2  entries held: 0, 1 or 2.
- StallCnt  out  16  present only with PIPE_STAGE_PERF_EN.
- FlushCnt  out  16  present only with PIPE_STAGE_PERF_EN.

## Operation
- States:
  - EMPTY: no entries.
  - FULL: main entry valid.
  - SKID: main and skid entries valid.
- Fire conditions: in_fire = InValid & InReady; out_fire = OutValid & OutReady.
- Derived outputs: InReady = (state != SKID); OutValid = (state != EMPTY); Occupancy = 0 / 1 / 2 for EMPTY / FULL / SKID.
- EMPTY: in_fire loads main from InData and moves to FULL.
- FULL:
  - in_fire & out_fire: main <= InData, stay FULL.
  - in_fire only: skid <= InData, go to SKID.
  - out_fire only: go to EMPTY.
  - neither: hold.
- SKID: out_fire moves skid to main and goes to FULL; otherwise hold. No in_fire is possible in SKID.
- Priority: Rst > Flush > normal operation.
- Flush:
  - Next state is EMPTY and both data registers load BUBBLE_DATA.
  - An in_fire in the flush cycle completes from the upstream view but its data is dropped.
  - An out_fire in the flush cycle completes normally.
- Ordering: entries leave in arrival order; the skid entry is never overtaken.
- Payload is opaque: no field decoding, no arithmetic.

## Timing
- Latency: entry accepted in cycle N is presented with OutValid=1 in cycle N+1.
- Throughput: one entry per cycle while OutReady=1.
- Handshake rules:
  - OutValid and OutData stay stable while OutValid=1 and OutReady=0.
  - InReady falls the cycle after the skid fills.
  - InReady rises the cycle after the skid drains.
- Reset values, applied on the first rising edge with Rst=1:
  - state EMPTY, OutValid 0, InReady 1, Occupancy 0.
  - OutData and both data registers BUBBLE_DATA.
  - StallCnt 0, FlushCnt 0.
- Reset mid-operation: held entries are lost. Handshakes in a cycle with Rst=1 have no effect on state.
- Flush together with Rst: reset wins; FlushCnt does not increment.

## Configuration
- PIPE_STAGE_PERF_EN defined:
  - StallCnt counts cycles with OutValid=1 and OutReady=0.
  - FlushCnt counts cycles with Flush=1 and Rst=0.
  - Both are 16-bit and saturate at 16'hFFFF; no wrap.
- PIPE_STAGE_PERF_EN undefined: the counter ports and their logic are absent; all other behaviour is identical.

## Structure
- Package pipe_pkg:
  - typedef enum pipe_state_t {PS_EMPTY, PS_FULL, PS_SKID}.
  - localparam PIPE_PERF_CNT_W = 16.
  - occupancy constants OCC_EMPTY=0, OCC_ONE=1, OCC_TWO=2.
- Sub-module pipe_sat_counter: width-parameterised saturating up-counter with synchronous clear and increment enable, instantiated twice under PIPE_STAGE_PERF_EN.
- Datapath is two DATA_W registers plus an output mux on state. No memories.

## Test plan
- Streaming: reset, DATA_W=32, OutReady=1, InValid=1 with data 1..8 on consecutive cycles -> OutData 1..8 on the following consecutive cycles; InReady stays 1; Occupancy stays 1.
- Backpressure: send 0xA then 0xB with OutReady=0 -> Occupancy 2 and InReady=0 on the next cycle. Raise OutReady -> 0xA then 0xB delivered; InReady returns to 1 one cycle after the skid drains.
- Flush while SKID: assert Flush with InValid=1, InData=0xC -> next cycle Occupancy 0, OutValid 0, OutData=BUBBLE_DATA (e.g. 32'h0000_001A); 0xC never appears.
- Reset mid-stream: Rst=1 while FULL -> next cycle OutValid 0, InReady 1, OutData=BUBBLE_DATA, no entry emitted.
- Counters (PIPE_STAGE_PERF_EN): hold OutValid=1 with OutReady=0 for 70000 cycles -> StallCnt=16'hFFFF. Then three Flush pulses -> FlushCnt=3.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding, counter width and occupancy codes for pipe_stage_reg
package pipe_pkg;
  typedef enum logic [1:0] {PS_EMPTY, PS_FULL, PS_SKID} pipe_state_t;
  localparam int PIPE_PERF_CNT_W = 16;
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;
endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: W-bit up-counter that sticks at all-ones, with sync reset, sync clear and increment enable
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  // clear beats increment; increment stops at all-ones instead of wrapping
  always_comb cnt_d = clr ? '0 : (en && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  // count register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready stage with two-entry skid buffer; PIPE_STAGE_PERF_EN adds stall/flush counters
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = 64,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = '0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [DATA_W-1:0] InData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutData,
  output logic [1:0]        Occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [PIPE_PERF_CNT_W-1:0] StallCnt,
  output logic [PIPE_PERF_CNT_W-1:0] FlushCnt
`endif
);
  pipe_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
  logic              in_fire, out_fire;
  assign InReady   = state_q != PS_SKID;
  assign OutValid  = state_q != PS_EMPTY;
  assign in_fire   = InValid && InReady;
  assign out_fire  = OutValid && OutReady;
  assign OutData   = OutValid ? main_q : BUBBLE_DATA;
  assign Occupancy = state_q == PS_SKID ? OCC_TWO : state_q == PS_FULL ? OCC_ONE : OCC_EMPTY;
  // next state and register loads; main is always the head, skid only ever holds the younger entry
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (Flush) begin
      state_d = PS_EMPTY;
      main_d  = BUBBLE_DATA;
      skid_d  = BUBBLE_DATA;
    end else begin
      case (state_q)
        PS_EMPTY: if (in_fire) begin
          main_d  = InData;
          state_d = PS_FULL;
        end
        PS_FULL: if (in_fire && out_fire) main_d = InData;
        else if (in_fire) begin
          skid_d  = InData;
          state_d = PS_SKID;
        end else if (out_fire) state_d = PS_EMPTY;
        PS_SKID: if (out_fire) begin
          main_d  = skid_q;
          state_d = PS_FULL;
        end
        default: state_d = PS_EMPTY;
      endcase
    end
  end
  // state and data registers; reset overrides flush and any handshake
  always_ff @(posedge Clk) begin
    state_q <= Rst ? PS_EMPTY : state_d;
    main_q  <= Rst ? BUBBLE_DATA : main_d;
    skid_q  <= Rst ? BUBBLE_DATA : skid_d;
  end
`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_counter #(.W(PIPE_PERF_CNT_W)) u_stall_cnt (
    .clk(Clk), .rst(Rst), .clr(1'b0), .en(OutValid && !OutReady), .cnt(StallCnt)
  );
  pipe_sat_counter #(.W(PIPE_PERF_CNT_W)) u_flush_cnt (
    .clk(Clk), .rst(Rst), .clr(1'b0), .en(Flush), .cnt(FlushCnt)
  );
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed + random scoreboard bench for pipe_stage_reg (counter checks when PIPE_STAGE_PERF_EN is defined)
module tb_pipe_stage_reg;
  localparam logic [31:0] BUB = 32'h0000_001A;
  logic        clk = 1'b0;
  logic        rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  occ;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif
  logic [31:0] q[$];
  logic [15:0] stall_m = '0, flush_m = '0;
  int          checks = 0, errors = 0;
  bit          chk_en = 1'b0;
  always #5 clk = ~clk;
  pipe_stage_reg #(.DATA_W(32), .BUBBLE_DATA(BUB)) dut (
    .Clk(clk), .Rst(rst), .Flush(flush), .InValid(in_valid), .InReady(in_ready), .InData(in_data),
    .OutValid(out_valid), .OutReady(out_ready), .OutData(out_data), .Occupancy(occ)
`ifdef PIPE_STAGE_PERF_EN
    , .StallCnt(stall_cnt), .FlushCnt(flush_cnt)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    bit inf, outf, stall;
    @(negedge clk);
    if (chk_en) begin
      chk("occupancy", 32'(occ), 32'(q.size()));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("out_data", out_data, q.size() > 0 ? q[0] : BUB);
`ifdef PIPE_STAGE_PERF_EN
      chk("stall_cnt", 32'(stall_cnt), 32'(stall_m));
      chk("flush_cnt", 32'(flush_cnt), 32'(flush_m));
`endif
    end
    inf   = in_valid && q.size() < 2;
    outf  = out_ready && q.size() > 0;
    stall = !out_ready && q.size() > 0;
    if (rst) begin
      q.delete();
      stall_m = '0;
      flush_m = '0;
    end else begin
      if (stall && stall_m != 16'hFFFF) stall_m++;
      if (flush && flush_m != 16'hFFFF) flush_m++;
      if (outf) void'(q.pop_front());
      if (flush) q.delete();
      else if (inf) q.push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_en = 1'b1;
    step();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int d = 1; d <= 8; d++) begin
      in_data = 32'(d);
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    step();
    in_data = 32'hB;
    step();
    in_valid = 1'b0;
    step();
    step();
    out_ready = 1'b1;
    repeat (3) step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    step();
    in_data = 32'h12;
    step();
    in_data = 32'hC;
    flush   = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    in_valid = 1'b1;
    in_data  = 32'h21;
    step();
    out_ready = 1'b1;
    in_data   = 32'hC;
    flush     = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h31;
    step();
    in_data = 32'h32;
    rst     = 1'b1;
    flush   = 1'b1;
    step();
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) step();
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = $urandom_range(0, 3) != 0 || i < 40 ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data   = $urandom;
      flush     = $urandom_range(0, 19) == 0;
      step();
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
`ifdef PIPE_STAGE_PERF_EN
    in_valid = 1'b1;
    in_data  = 32'h55;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (70000) step();
    chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) begin
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();
    end
    chk("flush_three", 32'(flush_cnt), 32'd3);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
